carfield_mailbox_responder: RTL and testbench
=============================================

Name: carfield_mailbox_responder

Overview:
- Register-bus responder (target side) for the Carfield inter-domain mailbox window.
- Default window: base 'h40000000, size 'h00001000.
- Decodes host/safety-island accesses into NumMbox mailbox slots, each with two data words, a doorbell, and an interrupt enable.
- Returns a one-deep buffered response with a valid/ready handshake.
- Drives one level interrupt per mailbox toward the receiving domain.

Parameters:
- NumMbox, 4, number of mailbox slots; 1..64, must satisfy NumMbox*'h20 <= Size.
- AddrWidth, 48, request address width.
- DataWidth, 32, data width; fixed at 32, other values rejected by assertion.
- BaseAddr, 'h40000000, window base address.
- Size, 'h00001000, window size in bytes; power of two.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
- req_addr_i  in  AddrWidth  byte address
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  32  write data
- req_wstrb_i  in  4  byte strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i
- rsp_rdata_o  out  32  read data; 0 for writes and errors
- rsp_error_o  out  1  decode error
- irq_o  out  NumMbox  per-mailbox interrupt, registered

Behaviour:
- Reset values (async, active-low):
  - FSM in IDLE; rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, irq_o=0.
  - All DATA0, DATA1, DOORBELL and IRQ_EN registers cleared to 0.
  - Reset mid-transaction drops any pending response; no response is ever emitted for it.
- Slot map: offset = addr - BaseAddr; slot i = offset[11:5]; word = offset[4:2].
  - 0x00 DATA0: RW, byte-strobed.
  - 0x04 DATA1: RW, byte-strobed.
  - 0x08 DOORBELL: write-1-to-set bit0 when wstrb[0]; reads {31'b0, db}.
  - 0x0C CLEAR: write-1-to-clear doorbell bit0 when wstrb[0]; reads 0.
  - 0x10 IRQ_EN: RW bit0 when wstrb[0]; upper bits read 0.
  - 0x14-0x1C: reserved.
- Decode error (rsp_error_o=1, rsp_rdata_o=0, no register side effect) when any of:
  - addr outside [BaseAddr, BaseAddr+Size)
  - addr[1:0] != 0
  - slot >= NumMbox
  - reserved word
- Writes with wstrb=0 complete OKAY with no effect.
- FSM states IDLE and RESP:
  - IDLE: req_ready_o=1. On accept, perform the register read/write in the same cycle, capture rdata/error into response registers, go to RESP.
  - RESP: req_ready_o=0, rsp_valid_o=1. Hold rdata/error stable until rsp_ready_i; on handshake go to IDLE.
  - Back-to-back throughput is one access per 2 cycles.
- Latency: response valid on the cycle after acceptance.
- Read-after-write: a read accepted after a write's response sees the written value.
- Doorbell set and clear never coincide (single port).
- irq_o[i] <= db[i] & en[i], registered, so one cycle after the updating access is accepted. Level-held until cleared or disabled.
- Setting an already-set doorbell: no change, no extra pulse.

Test Plan:
- Reset with rsp_ready_i=1 → rsp_valid_o=0, irq_o=0. Read 'h40000000 → rdata 0, error 0, rsp_valid_o asserted exactly 1 cycle after accept.
- Write DATA1 of slot 2 ('h40000044) with 'hDEADBEEF, wstrb 4'b0101 → readback 'h00AD00EF.
- Write IRQ_EN slot 1=1, then DOORBELL slot 1=1 → irq_o=4'b0010 one cycle after accept. Write CLEAR slot 1=1 → irq_o=0.
- Error cases, each → error 1, rdata 0, registers unchanged:
  - read 'h40000080 (slot 4 ≥ NumMbox)
  - read 'h40000014 (reserved)
  - read 'h40000002 (misaligned)
  - read 'h40001000 (outside window)
- Hold rsp_ready_i=0 for 5 cycles → rsp_valid_o and data stable, req_ready_o=0, a second request is not accepted. Release → handshake, then IDLE.
- Assert rst_ni low while in RESP → rsp_valid_o drops immediately and all registers read 0 after release.

Source files
------------

// File: rtl/carfield_mailbox_responder.sv
// Target-side register responder for the Carfield inter-domain mailbox window.
// Each slot holds two data words, a doorbell and an interrupt enable; responses are one-deep.
module carfield_mailbox_responder #(
  parameter int unsigned          NumMbox   = 4,
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 32,
  parameter logic [AddrWidth-1:0] BaseAddr  = 'h40000000,
  parameter logic [AddrWidth-1:0] Size      = 'h00001000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NumMbox-1:0]     irq_o
);

  localparam int unsigned SlotW   = (NumMbox > 1) ? $clog2(NumMbox) : 1;
  localparam int unsigned SlotHiW = AddrWidth - 5;

  if (DataWidth != 32) begin : gen_dw_check
    $error("carfield_mailbox_responder: DataWidth must be 32");
  end
  if (NumMbox < 1 || NumMbox > 64) begin : gen_num_check
    $error("carfield_mailbox_responder: NumMbox must be in 1..64");
  end
  if ((64'(NumMbox) << 5) > 64'(Size)) begin : gen_size_check
    $error("carfield_mailbox_responder: window too small for NumMbox slots");
  end
  if (Size == '0 || (Size & (Size - AddrWidth'(1))) != '0) begin : gen_pow2_check
    $error("carfield_mailbox_responder: Size must be a power of two");
  end

  typedef enum logic {StIdle, StResp} state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] data0_q [NumMbox];
  logic [DataWidth-1:0] data0_d [NumMbox];
  logic [DataWidth-1:0] data1_q [NumMbox];
  logic [DataWidth-1:0] data1_d [NumMbox];
  logic [NumMbox-1:0]   db_q, db_d, en_q, en_d, irq_q;
  logic [DataWidth-1:0] rdata_q, rdata_d, rd_val;
  logic                 error_q, error_d;

  logic [AddrWidth-1:0] offset;
  logic [SlotHiW-1:0]   slot_hi;
  logic [SlotW-1:0]     slot_sel;
  logic [2:0]           word;
  logic                 in_window, slot_ok, aligned, word_ok, dec_err;

  function automatic logic [DataWidth-1:0] merge_bytes(input logic [DataWidth-1:0]   old_val,
                                                       input logic [DataWidth-1:0]   new_val,
                                                       input logic [DataWidth/8-1:0] strb);
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int b = 0; b < DataWidth / 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Subtract before comparing so BaseAddr+Size never has to be formed (no overflow).
  assign offset    = req_addr_i - BaseAddr;
  assign in_window = (req_addr_i >= BaseAddr) && (offset < Size);
  assign slot_hi   = offset[AddrWidth-1:5];
  assign slot_ok   = slot_hi < SlotHiW'(NumMbox);
  assign slot_sel  = slot_hi[SlotW-1:0];
  assign word      = offset[4:2];
  assign aligned   = (offset[1:0] == 2'b00);
  assign word_ok   = (word <= 3'd4);
  assign dec_err   = !(in_window && slot_ok && aligned && word_ok);

  always_comb begin
    rd_val = '0;
    case (word)
      3'd0:    rd_val = data0_q[slot_sel];
      3'd1:    rd_val = data1_q[slot_sel];
      3'd2:    rd_val = {{(DataWidth-1){1'b0}}, db_q[slot_sel]};
      3'd4:    rd_val = {{(DataWidth-1){1'b0}}, en_q[slot_sel]};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    data1_d = data1_q;
    db_d    = db_q;
    en_d    = en_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StResp;
          error_d = dec_err;
          rdata_d = (dec_err || req_write_i) ? '0 : rd_val;
          if (req_write_i && !dec_err) begin
            case (word)
              3'd0: data0_d[slot_sel] = merge_bytes(data0_q[slot_sel], req_wdata_i, req_wstrb_i);
              3'd1: data1_d[slot_sel] = merge_bytes(data1_q[slot_sel], req_wdata_i, req_wstrb_i);
              3'd2: if (req_wstrb_i[0] && req_wdata_i[0]) db_d[slot_sel] = 1'b1;
              3'd3: if (req_wstrb_i[0] && req_wdata_i[0]) db_d[slot_sel] = 1'b0;
              3'd4: if (req_wstrb_i[0]) en_d[slot_sel] = req_wdata_i[0];
              default: ;
            endcase
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      data0_q <= '{default: '0};
      data1_q <= '{default: '0};
      db_q    <= '0;
      en_q    <= '0;
      irq_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      db_q    <= db_d;
      en_q    <= en_d;
      // Built from next-state so the level appears together with the response.
      irq_q   <= db_d & en_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_carfield_mailbox_responder.sv
// Directed bench for the mailbox responder: reset, strobes, doorbell/irq, decode errors,
// response backpressure and reset during a pending response.
module tb_carfield_mailbox_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [47:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [3:0]  irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        er, v1;
  logic [3:0]  ia;

  carfield_mailbox_responder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_write_i(req_write),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  // One transaction with rsp_ready held high; samples response and irq 1 time unit after accept.
  task automatic access(input logic [47:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] ws);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%h ready=%b need=1", addr, req_ready);
      req_valid = 1'b0; rd = 'x; er = 1'bx; v1 = 1'bx; ia = 'x;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    v1 = rsp_valid; rd = rsp_rdata; er = rsp_error; ia = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    total++; if (irq !== 4'h0) begin bad++; $display("FAIL rst_irq got=%h exp=0", irq); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    access(48'h40000000, 1'b0, '0, '0);
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL rd0_latency got=%b exp=1", v1); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rd0_data got=%h exp=0", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rd0_err got=%b exp=0", er); end
  endtask

  task automatic test_strobe();
    access(48'h40000044, 1'b1, 32'hDEADBEEF, 4'b0101);
    total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL wr_rsp got=%b/%h exp=0/0", er, rd); end
    access(48'h40000044, 1'b0, '0, '0);
    total++; if (rd !== 32'h00AD00EF) begin bad++; $display("FAIL strobe_rd got=%h exp=00ad00ef", rd); end
    access(48'h40000044, 1'b1, 32'hFFFFFFFF, 4'b0000);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL nostrb_err got=%b exp=0", er); end
    access(48'h40000044, 1'b0, '0, '0);
    total++; if (rd !== 32'h00AD00EF) begin bad++; $display("FAIL nostrb_rd got=%h exp=00ad00ef", rd); end
    access(48'h40000040, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL data0_s2 got=%h exp=0", rd); end
  endtask

  task automatic test_irq();
    access(48'h40000030, 1'b1, 32'h1, 4'b0001);
    total++; if (ia !== 4'b0000) begin bad++; $display("FAIL en_only_irq got=%b exp=0000", ia); end
    access(48'h40000028, 1'b1, 32'h1, 4'b0001);
    total++; if (ia !== 4'b0010) begin bad++; $display("FAIL db_irq got=%b exp=0010", ia); end
    access(48'h40000028, 1'b0, '0, '0);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL db_rd got=%h exp=1", rd); end
    access(48'h4000002C, 1'b0, '0, '0);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL clr_rd got=%h/%b exp=0/0", rd, er); end
    access(48'h40000030, 1'b0, '0, '0);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL en_rd got=%h exp=1", rd); end
    access(48'h40000028, 1'b1, 32'h1, 4'b0001);
    total++; if (irq !== 4'b0010) begin bad++; $display("FAIL db_reset_irq got=%b exp=0010", irq); end
    access(48'h4000002C, 1'b1, 32'h1, 4'b0001);
    total++; if (ia !== 4'b0000) begin bad++; $display("FAIL clr_irq got=%b exp=0000", ia); end
    access(48'h40000028, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL db_after_clr got=%h exp=0", rd); end
  endtask

  task automatic test_errors();
    logic [47:0] addrs [5];
    addrs = '{48'h40000080, 48'h40000014, 48'h40000002, 48'h40001000, 48'h3FFFFFFC};
    foreach (addrs[i]) begin
      access(addrs[i], 1'b0, '0, '0);
      total++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        bad++; $display("FAIL err_rd addr=%h got=%b/%h exp=1/0", addrs[i], er, rd);
      end
    end
    access(48'h40000046, 1'b1, 32'hFFFFFFFF, 4'b1111);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL err_wr got=%b exp=1", er); end
    access(48'h40000044, 1'b0, '0, '0);
    total++; if (rd !== 32'h00AD00EF) begin bad++; $display("FAIL err_no_effect got=%h exp=00ad00ef", rd); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 48'h40000044; req_write = 1'b0; req_wstrb = '0;
    @(posedge clk);
    #1;
    req_addr = 48'h40000040; req_write = 1'b1; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00AD00EF || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold cyc=%0d got v=%b d=%h e=%b r=%b exp v=1 d=00ad00ef e=0 r=0",
                 c, rsp_valid, rsp_rdata, rsp_error, req_ready);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL release got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready);
    end
    access(48'h40000040, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL held_req_ignored got=%h exp=0", rd); end
  endtask

  task automatic test_reset_mid();
    access(48'h40000000, 1'b1, 32'h12345678, 4'hF);
    access(48'h40000010, 1'b1, 32'h1, 4'h1);
    access(48'h40000008, 1'b1, 32'h1, 4'h1);
    total++; if (ia !== 4'b0001) begin bad++; $display("FAIL pre_rst_irq got=%b exp=0001", ia); end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 48'h40000000; req_write = 1'b0; req_wstrb = '0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      bad++; $display("FAIL pre_rst_rsp got v=%b d=%h exp v=1 d=12345678", rsp_valid, rsp_rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || irq !== 4'h0) begin
      bad++; $display("FAIL async_rst got v=%b irq=%b exp v=0 irq=0000", rsp_valid, irq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ghost_rsp got=%b exp=0", rsp_valid); end
    end
    access(48'h40000000, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_d0 got=%h exp=0", rd); end
    access(48'h40000008, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_db got=%h exp=0", rd); end
    access(48'h40000010, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_en got=%h exp=0", rd); end
    access(48'h40000044, 1'b0, '0, '0);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL post_rst_d1 got=%h exp=0", rd); end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_irq();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
